// File: rtl/mem_bus_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the memory-bus controller:
//   - state_t        : controller FSM state encoding (ST_IDLE/ST_ACCESS/ST_ERROR)
//   - DEF_REGION_*   : default base/mask/wait tables for the current memory map
//                      (region 0 = instruction memory, 1 = data memory, 2 = GPIO)
//   - ERRCNT_W       : width of the saturating bus-error counter
// ---------------------------------------------------------------------------
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_NUM_REGIONS = 3;
    localparam int DEF_WS_W        = 4;

    // Packed tables: region i lives at [i*width +: width].
    localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE =
        {32'h0100_0000, 32'h0010_0000, 32'h0000_0000};
    localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_MASK =
        {32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_F000};
    localparam logic [DEF_NUM_REGIONS*DEF_WS_W-1:0]   DEF_REGION_WAIT =
        {4'd2, 4'd1, 4'd0};

    localparam int ERRCNT_W = 8;

endpackage

// File: rtl/mem_region_decoder.sv
// ---------------------------------------------------------------------------
// mem_region_decoder
// Combinational address decoder. Region i hits when (addr & MASK_i) == BASE_i;
// on overlapping regions the lowest index wins.
// Ports:
//   i_addr   : address to decode
//   o_hit    : at least one region matched
//   o_idx    : index of the winning region (0 when no hit)
//   o_offset : addr & ~MASK of the winning region (0 when no hit)
// ---------------------------------------------------------------------------
module mem_region_decoder
    import mem_bus_pkg::*;
#(
    parameter int addressWidth = DEF_ADDR_W,
    parameter int NUM_REGIONS  = DEF_NUM_REGIONS,
    parameter int IDX_W        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
    parameter logic [NUM_REGIONS*addressWidth-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*addressWidth-1:0] REGION_MASK = DEF_REGION_MASK
) (
    input  logic [addressWidth-1:0] i_addr,
    output logic                    o_hit,
    output logic [IDX_W-1:0]        o_idx,
    output logic [addressWidth-1:0] o_offset
);

    logic [NUM_REGIONS-1:0] w_hit_vec;
    logic [IDX_W-1:0]       w_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_match
            assign w_hit_vec[gi] =
                ((i_addr & REGION_MASK[gi*addressWidth +: addressWidth])
                 == REGION_BASE[gi*addressWidth +: addressWidth]);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign o_hit    = |w_hit_vec;
    assign o_idx    = w_idx;
    assign o_offset = o_hit ? (i_addr & ~REGION_MASK[int'(w_idx)*addressWidth +: addressWidth])
                            : '0;

endmodule

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
// Memory-bus controller between a byte-wide CPU memory port and NUM_REGIONS
// address-mapped slaves. Each access is decoded against a base/mask table,
// held for a per-region number of wait states, and completed with a one-cycle
// memDataReady pulse. Unmapped accesses, or read+write asserted together,
// complete one cycle later with busError and bump a saturating error counter.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   readmem, writemem        : CPU request, held until memDataReady
//   addressBus, dataBusIn    : CPU address / write data
//   dataBusOut               : read data, valid with memDataReady (else 0)
//   memDataReady, busError   : completion pulse / error flag on completion
//   errCount                 : saturating count of errored accesses
//   slave_sel                : one-hot select of the active region (ACCESS only)
//   slave_addr, slave_wdata  : latched region offset / write data
//   slave_write              : one-cycle write strobe, coincides with ready
//   slave_rdata              : packed slave read data, region i at [i*dataWidth +: dataWidth]
// ---------------------------------------------------------------------------
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int dataWidth    = 8,
    parameter int addressWidth = DEF_ADDR_W,
    parameter int NUM_REGIONS  = DEF_NUM_REGIONS,
    parameter int WS_WIDTH     = DEF_WS_W,
    parameter logic [NUM_REGIONS*addressWidth-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*addressWidth-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter logic [NUM_REGIONS*WS_WIDTH-1:0]     REGION_WAIT = DEF_REGION_WAIT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             readmem,
    input  logic                             writemem,
    input  logic [addressWidth-1:0]          addressBus,
    input  logic [dataWidth-1:0]             dataBusIn,
    output logic [dataWidth-1:0]             dataBusOut,
    output logic                             memDataReady,
    output logic                             busError,
    output logic [ERRCNT_W-1:0]              errCount,
    output logic [NUM_REGIONS-1:0]           slave_sel,
    output logic [addressWidth-1:0]          slave_addr,
    output logic [dataWidth-1:0]             slave_wdata,
    output logic                             slave_write,
    input  logic [NUM_REGIONS*dataWidth-1:0] slave_rdata
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    // Registered state
    state_t                  r_state;
    logic [WS_WIDTH-1:0]     r_cnt;
    logic [IDX_W-1:0]        r_region;
    logic                    r_write;
    logic [addressWidth-1:0] r_slave_addr;
    logic [dataWidth-1:0]    r_slave_wdata;
    logic [ERRCNT_W-1:0]     r_err_count;

    // Next-state values
    state_t                  w_state_next;
    logic [WS_WIDTH-1:0]     w_cnt_next;
    logic [IDX_W-1:0]        w_region_next;
    logic                    w_write_next;
    logic [addressWidth-1:0] w_slave_addr_next;
    logic [dataWidth-1:0]    w_slave_wdata_next;
    logic [ERRCNT_W-1:0]     w_err_count_next;

    // Combinational outputs
    logic                    w_ready;
    logic                    w_bus_err;
    logic                    w_strobe;
    logic [dataWidth-1:0]    w_rdata;

    // Decode results
    logic                    w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic [addressWidth-1:0] w_offset;
    logic [WS_WIDTH-1:0]     w_wait;
    logic [dataWidth-1:0]    w_sel_rdata;
    logic                    w_req;
    logic                    w_both;

    mem_region_decoder #(
        .addressWidth (addressWidth),
        .NUM_REGIONS  (NUM_REGIONS),
        .IDX_W        (IDX_W),
        .REGION_BASE  (REGION_BASE),
        .REGION_MASK  (REGION_MASK)
    ) u_decoder (
        .i_addr   (addressBus),
        .o_hit    (w_hit),
        .o_idx    (w_idx),
        .o_offset (w_offset)
    );

    assign w_req       = readmem | writemem;
    assign w_both      = readmem & writemem;
    assign w_wait      = REGION_WAIT[int'(w_idx)*WS_WIDTH +: WS_WIDTH];
    // Slaves answer combinationally from slave_addr, so the read mux uses the
    // latched region rather than the live decode.
    assign w_sel_rdata = slave_rdata[int'(r_region)*dataWidth +: dataWidth];

    // Next-state and output logic
    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_region_next      = r_region;
        w_write_next       = r_write;
        w_slave_addr_next  = r_slave_addr;
        w_slave_wdata_next = r_slave_wdata;
        w_err_count_next   = r_err_count;
        w_ready            = 1'b0;
        w_bus_err          = 1'b0;
        w_strobe           = 1'b0;
        w_rdata            = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_hit && !w_both) begin
                        w_region_next      = w_idx;
                        w_write_next       = writemem;
                        w_slave_addr_next  = w_offset;
                        w_slave_wdata_next = dataBusIn;
                        w_cnt_next         = w_wait;
                        w_state_next       = ST_ACCESS;
                    end else begin
                        w_state_next = ST_ERROR;
                    end
                end
            end

            ST_ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_ready = 1'b1;
                    if (r_write) begin
                        w_strobe = 1'b1;
                    end else begin
                        w_rdata = w_sel_rdata;
                    end
                    w_state_next = ST_IDLE;
                end
            end

            ST_ERROR: begin
                w_ready   = 1'b1;
                w_bus_err = 1'b1;
                if (r_err_count != {ERRCNT_W{1'b1}}) begin
                    w_err_count_next = r_err_count + 1'b1;
                end
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_region      <= '0;
            r_write       <= 1'b0;
            r_slave_addr  <= '0;
            r_slave_wdata <= '0;
            r_err_count   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_region      <= w_region_next;
            r_write       <= w_write_next;
            r_slave_addr  <= w_slave_addr_next;
            r_slave_wdata <= w_slave_wdata_next;
            r_err_count   <= w_err_count_next;
        end
    end

    // One-hot select, only while an access is in flight.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_sel
            assign slave_sel[gi] = (r_state == ST_ACCESS) && (int'(r_region) == gi);
        end
    endgenerate

    assign dataBusOut   = w_rdata;
    assign memDataReady = w_ready;
    assign busError     = w_bus_err;
    assign errCount     = r_err_count;
    assign slave_addr   = r_slave_addr;
    assign slave_wdata  = r_slave_wdata;
    assign slave_write  = w_strobe;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        readmem;
    logic        writemem;
    logic [31:0] addressBus;
    logic [7:0]  dataBusIn;
    logic [7:0]  dataBusOut;
    logic        memDataReady;
    logic        busError;
    logic [7:0]  errCount;
    logic [2:0]  slave_sel;
    logic [31:0] slave_addr;
    logic [7:0]  slave_wdata;
    logic        slave_write;
    logic [23:0] slave_rdata;

    always #5 clk = ~clk;

    // Slave model: each region returns its own tag XOR the low offset byte.
    assign slave_rdata = {8'hC3 ^ slave_addr[7:0], 8'h5A ^ slave_addr[7:0], 8'hA1 ^ slave_addr[7:0]};

    mem_bus_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .readmem      (readmem),
        .writemem     (writemem),
        .addressBus   (addressBus),
        .dataBusIn    (dataBusIn),
        .dataBusOut   (dataBusOut),
        .memDataReady (memDataReady),
        .busError     (busError),
        .errCount     (errCount),
        .slave_sel    (slave_sel),
        .slave_addr   (slave_addr),
        .slave_wdata  (slave_wdata),
        .slave_write  (slave_write),
        .slave_rdata  (slave_rdata)
    );

    typedef struct {
        logic [7:0]  data;
        logic        err;
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [7:0]  wdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    int          obs_lat;
    logic [31:0] obs_addr_first;
    logic        obs_addr_seen;
    logic        obs_bad_strobe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic e, input logic w,
                                input logic [2:0] s, input logic [31:0] a,
                                input logic [7:0] wd, input int l);
        exp_t r;
        r.data = d; r.err = e; r.wr = w; r.sel = s; r.addr = a; r.wdata = wd; r.lat = l;
        return r;
    endfunction

    // Counts edges until memDataReady (bounded), recording the slave address
    // at the first ACCESS cycle and any write strobe seen before ready.
    task automatic wait_ready(input logic chg, input logic [31:0] a_chg);
        obs_lat        = 0;
        obs_addr_seen  = 1'b0;
        obs_addr_first = '0;
        obs_bad_strobe = 1'b0;
        do begin
            @(posedge clk);
            #1;
            obs_lat++;
            if (obs_lat == 1 && chg) addressBus = a_chg;
            if (!obs_addr_seen && slave_sel != 3'b000) begin
                obs_addr_seen  = 1'b1;
                obs_addr_first = slave_addr;
            end
            if (slave_write && !memDataReady) obs_bad_strobe = 1'b1;
        end while (!memDataReady && obs_lat < 40);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_underflow observed=ready expected=no_pending");
            return;
        end
        e = sb.pop_front();
        txn++;
        $display("txn %0d err=%0b wr=%0b lat=%0d data=%02h sel=%03b addr=%08h errCount=%0d",
                 txn, busError, slave_write, obs_lat, dataBusOut, slave_sel, slave_addr, errCount);
        check("latency",    obs_lat,        e.lat);
        check("ready",      memDataReady,   1'b1);
        check("busError",   busError,       e.err);
        check("slave_write", slave_write,   e.wr);
        check("early_strobe", obs_bad_strobe, 1'b0);
        check("dataBusOut", dataBusOut,     e.data);
        check("slave_sel",  slave_sel,      e.sel);
        if (!e.err) begin
            check("slave_addr",       slave_addr,     e.addr);
            check("slave_addr_first", obs_addr_first, e.addr);
            if (e.wr) check("slave_wdata", slave_wdata, e.wdata);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [7:0] wd, input logic chg, input logic [31:0] a_chg,
                          input exp_t e);
        readmem    = rd;
        writemem   = wr;
        addressBus = a;
        dataBusIn  = wd;
        sb.push_back(e);
        wait_ready(chg, a_chg);
        readmem  = 1'b0;
        writemem = 1'b0;
        compare_front();
        @(posedge clk);
        #1;
        check("ready_one_cycle", memDataReady, 1'b0);
    endtask

    exp_t err_e;
    logic strobe_seen;

    initial begin
        rst = 1'b1; readmem = 1'b0; writemem = 1'b0; addressBus = '0; dataBusIn = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   memDataReady, 1'b0);
        check("rst_busErr",  busError,     1'b0);
        check("rst_write",   slave_write,  1'b0);
        check("rst_sel",     slave_sel,    3'b000);
        check("rst_dout",    dataBusOut,   8'h00);
        check("rst_addr",    slave_addr,   32'h0);
        check("rst_wdata",   slave_wdata,  8'h00);
        check("rst_errCount", errCount,    8'd0);
        rst = 1'b0;

        // Region 0 read, no wait states.
        access(1'b1, 1'b0, 32'h0000_0004, 8'h00, 1'b0, '0,
               mk(8'hA5, 1'b0, 1'b0, 3'b001, 32'h004, 8'h00, 1));
        // Region 1 write, one wait state.
        access(1'b0, 1'b1, 32'h0010_0020, 8'h3C, 1'b0, '0,
               mk(8'h00, 1'b0, 1'b1, 3'b010, 32'h020, 8'h3C, 2));
        // Region 2 read, two wait states, address changes mid-access.
        access(1'b1, 1'b0, 32'h0100_0003, 8'h00, 1'b1, 32'h0100_000F,
               mk(8'hC3 ^ 8'h03, 1'b0, 1'b0, 3'b100, 32'h003, 8'h00, 3));

        // Errors: unmapped address, then read and write together.
        err_e = mk(8'h00, 1'b1, 1'b0, 3'b000, 32'h0, 8'h00, 1);
        access(1'b1, 1'b0, 32'h2000_0000, 8'h00, 1'b0, '0, err_e);
        access(1'b1, 1'b1, 32'h0000_0000, 8'h11, 1'b0, '0, err_e);
        check("errCount_2", errCount, 8'd2);

        for (int i = 0; i < 253; i++) access(1'b1, 1'b0, 32'h2000_0000, 8'h00, 1'b0, '0, err_e);
        check("errCount_255", errCount, 8'd255);
        for (int i = 0; i < 45; i++) access(1'b0, 1'b1, 32'h3000_0000, 8'h00, 1'b0, '0, err_e);
        check("errCount_sat", errCount, 8'd255);

        // Region 2 write aborted by reset in its second ACCESS cycle.
        strobe_seen = 1'b0;
        writemem = 1'b1; addressBus = 32'h0100_0005; dataBusIn = 8'h77;
        @(posedge clk); #1;
        strobe_seen |= slave_write | memDataReady;
        @(posedge clk); #1;
        strobe_seen |= slave_write | memDataReady;
        rst = 1'b1;
        @(posedge clk); #1;
        strobe_seen |= slave_write | memDataReady;
        check("abort_no_strobe", strobe_seen, 1'b0);
        check("abort_ready",    memDataReady, 1'b0);
        check("abort_busErr",   busError,     1'b0);
        check("abort_sel",      slave_sel,    3'b000);
        check("abort_addr",     slave_addr,   32'h0);
        check("abort_wdata",    slave_wdata,  8'h00);
        check("abort_dout",     dataBusOut,   8'h00);
        check("abort_errCount", errCount,     8'd0);
        rst = 1'b0; writemem = 1'b0;
        $display("txn %0d aborted write by reset, outputs at reset values", ++txn);

        access(1'b1, 1'b0, 32'h0000_0007, 8'h00, 1'b0, '0,
               mk(8'hA1 ^ 8'h07, 1'b0, 1'b0, 3'b001, 32'h007, 8'h00, 1));

        // Back-to-back reads, request held: ready at T+1 and T+4.
        sb.push_back(mk(8'hA5, 1'b0, 1'b0, 3'b001, 32'h004, 8'h00, 1));
        sb.push_back(mk(8'h5A ^ 8'h08, 1'b0, 1'b0, 3'b010, 32'h008, 8'h00, 3));
        readmem = 1'b1; addressBus = 32'h0000_0004;
        wait_ready(1'b0, '0);
        compare_front();
        addressBus = 32'h0010_0008;
        wait_ready(1'b0, '0);
        readmem = 1'b0;
        compare_front();
        @(posedge clk); #1;
        check("b2b_ready_one_cycle", memDataReady, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Parametrised memory-bus controller between the CPU's byte-wide memory port and N address-mapped slaves (instruction memory, data memory, GPIO, later peripherals). It decodes each access against a per-region base/mask table, inserts a per-region number of wait states, and answers with a one-cycle `memDataReady` handshake instead of a constant ready. Unmapped or malformed accesses complete with a bus-error pulse and are counted.

## Interface
Parameters:
- `dataWidth`, 8: data bus width.
- `addressWidth`, 32: address bus width.
- `NUM_REGIONS`, 3: number of slave regions.
- `WS_WIDTH`, 4: width of each wait-state count.
- `REGION_BASE`, {32'h0100_0000, 32'h0010_0000, 32'h0000_0000}: packed bases; region i is `[i*addressWidth +: addressWidth]`.
- `REGION_MASK`, {32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_F000}: packed match masks, same packing.
- `REGION_WAIT`, {4'd2, 4'd1, 4'd0}: packed wait states, region i is `[i*WS_WIDTH +: WS_WIDTH]`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `readmem` in 1: read request, held until `memDataReady`.
- `writemem` in 1: write request, held until `memDataReady`.
- `addressBus` in addressWidth: CPU address.
- `dataBusIn` in dataWidth: write data.
- `dataBusOut` out dataWidth: read data, valid only with `memDataReady`.
- `memDataReady` out 1: one-cycle completion pulse.
- `busError` out 1: asserted with `memDataReady` on an errored access.
- `errCount` out 8: saturating count of errored accesses.
- `slave_sel` out NUM_REGIONS: one-hot select of the active region.
- `slave_addr` out addressWidth: region offset, `addr & ~MASK_i`.
- `slave_wdata` out dataWidth: latched write data.
- `slave_write` out 1: one-cycle write strobe.
- `slave_rdata` in NUM_REGIONS*dataWidth: packed slave read data, region i at `[i*dataWidth +: dataWidth]`.

## Operation
- States: IDLE, ACCESS, ERROR.
- IDLE, request seen (`readmem|writemem`):
  - Decode: region i hits when `(addressBus & MASK_i) == BASE_i`. The lowest hitting index wins on overlap.
  - On a hit: latch op, region, `slave_addr`, and `slave_wdata`; load the counter with `WAIT_i`; go to ACCESS.
  - No hit, or `readmem` and `writemem` both high: go to ERROR.
- ACCESS:
  - `slave_sel` is one-hot for the latched region.
  - While counter ≠ 0: decrement.
  - At counter == 0:
    - `memDataReady=1`.
    - Read: `dataBusOut` = selected `slave_rdata` slice, combinational from the slave.
    - Write: `slave_write=1` and `dataBusOut=0`.
    - Next state IDLE.
- ERROR:
  - `memDataReady=1`, `busError=1`, `dataBusOut=0`. No `slave_sel`, no `slave_write`.
  - `errCount` increments, saturating at 255.
  - Next state IDLE.
- Request inputs are sampled only in IDLE. Changes during ACCESS are ignored.
- A request still high in the IDLE cycle after `memDataReady` is a new access. The CPU drops it in that cycle.
- Reset in any state: go to IDLE immediately. No write strobe is issued, and the access is abandoned.
- Reset values: `memDataReady`, `busError`, `slave_write`, and `slave_sel` are 0; `dataBusOut`, `slave_addr`, and `slave_wdata` are 0; `errCount` is 0.

## Timing
- Request first high in IDLE at cycle T on region i: `memDataReady` at T+1+WAIT_i for exactly one cycle.
- Error response at T+1.
- Write strobe coincides with `memDataReady`. `slave_addr`, `slave_wdata`, and `slave_sel` are stable from T+1 through the ready cycle.
- Slaves present read data combinationally from `slave_addr` within the ready cycle.
- Maximum throughput: one access per 2+WAIT_i cycles.
- Counter width is WS_WIDTH. WAIT=2^WS_WIDTH−1 gives the maximum latency of 2^WS_WIDTH cycles; there is no wrap.

## Structure
- Package `mem_bus_pkg`:
  - state encoding constants `ST_IDLE`, `ST_ACCESS`, `ST_ERROR`;
  - default region base/mask/wait constants for the current memory map;
  - `ERRCNT_W = 8`.
- Sub-module `mem_region_decoder`: combinational priority match of address against the table. Outputs hit, region index, and offset.
- The controller holds the FSM, counter, latches, and `errCount`.

## Test plan
- Read 0x0000_0004, region 0 wait 0, slave0 data 0xA5: `memDataReady` at T+1, `dataBusOut=0xA5`, `slave_sel=3'b001`, `slave_addr=0x004`.
- Write 0x3C to 0x0010_0020, region 1 wait 1: `slave_write` and ready at T+2, `slave_addr=0x020`, `slave_wdata=0x3C`, `slave_sel=3'b010`.
- Read 0x0100_0003, region 2 wait 2: ready at T+3, `slave_addr=0x3`. An address change during ACCESS does not alter `slave_addr`.
- Read 0x2000_0000 (unmapped), then `readmem` and `writemem` both high to 0x0: two ERROR responses, each with ready and `busError` at T+1, no `slave_write`; `errCount=2`. After 300 errors `errCount=255`.
- Write to region 2 with `rst` asserted at T+2: no `slave_write`, no ready; all outputs at reset values at T+3; the next request is serviced normally.
- Back-to-back reads to regions 0 and 1, request held continuously: two ready pulses at T+1 and T+4.
